// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: PC register, sync-read imem addressing, WB-stage
// redirect resolution, downstream stall, and the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter logic [31:0] PC_STEP       = 32'd1,
    parameter int unsigned SQUASH_CYCLES = 1,
    parameter int unsigned PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              wb_BranchZ,
    input  logic              wb_BranchN,
    input  logic              wb_Jump,
    input  logic              wb_JumpMem,
    input  logic              wb_Z,
    input  logic              wb_N,
    input  logic [31:0]       reg_target,
    input  logic [31:0]       mem_target,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       pc_out,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_instr,
    output logic              id_valid,
    output logic              redirect,
    output logic [PERF_W-1:0] fetch_count
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_pc, w_pc_nxt, w_target;
    logic [31:0]       r_id_pc, r_id_instr;
    logic              r_id_valid, w_id_valid_nxt;
    logic [PERF_W-1:0] r_fetch_count;
    logic [2:0]        r_squash, w_squash_nxt;
    logic              w_redirect, w_load_id, w_count_en;

    assign w_redirect = wb_Jump | wb_JumpMem | (wb_BranchZ & wb_Z) | (wb_BranchN & wb_N);
    assign w_target   = wb_JumpMem ? mem_target : reg_target;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_squash_nxt   = r_squash;
        w_id_valid_nxt = r_id_valid;
        w_load_id      = 1'b0;
        w_count_en     = 1'b0;
        if (w_redirect) begin
            w_pc_nxt       = w_target;
            w_squash_nxt   = SQ_RELOAD;
            w_id_valid_nxt = 1'b0;
            w_state_nxt    = (SQ_RELOAD != 3'd0) ? S_FLUSH : S_RUN;
        end else if (r_state == S_BOOT) begin
            w_state_nxt = S_RUN;
        end else if (!stall) begin
            w_pc_nxt  = r_pc + PC_STEP;
            w_load_id = 1'b1;
            if (r_state == S_FLUSH) begin
                // squashed slot still loads pc/instr so IF/ID tracks the fetch stream
                w_id_valid_nxt = 1'b0;
                w_squash_nxt   = r_squash - 3'd1;
                if (r_squash == 3'd1) begin
                    w_state_nxt = S_RUN;
                end
            end else begin
                w_id_valid_nxt = 1'b1;
                w_count_en     = 1'b1;
            end
        end
    end

    // BOOT re-reads RESET_PC so the first RUN cycle sees I(pc_out)
    assign imem_addr = (r_state == S_BOOT) ? RESET_PC : w_pc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_id_pc       <= '0;
            r_id_instr    <= '0;
            r_id_valid    <= 1'b0;
            r_fetch_count <= '0;
            r_squash      <= '0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_id_valid <= w_id_valid_nxt;
            if (w_load_id) begin
                r_id_pc    <= r_pc;
                r_id_instr <= imem_rdata;
            end
            if (w_count_en && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + PERF_W'(1);
            end
        end
    end

    assign pc_out      = r_pc;
    assign id_pc       = r_id_pc;
    assign id_instr    = r_id_instr;
    assign id_valid    = r_id_valid;
    assign redirect    = w_redirect;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: two instances (single-slot squash, and
// three-slot squash with a narrow saturating counter) driven by shared stimulus.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        bz = 1'b0, bn = 1'b0, jmp = 1'b0, jmem = 1'b0, fz = 1'b0, fn = 1'b0;
    logic [31:0] rtgt = '0, mtgt = '0;

    logic [31:0] a_addr[2], a_rdata[2], a_pc[2], a_idpc[2], a_idin[2], a_fc[2];
    logic        a_idv[2], a_red[2];
    logic [31:0] fc0;
    logic [3:0]  fc1;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(32'd1), .SQUASH_CYCLES(1), .PERF_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .wb_BranchZ(bz), .wb_BranchN(bn), .wb_Jump(jmp), .wb_JumpMem(jmem),
        .wb_Z(fz), .wb_N(fn), .reg_target(rtgt), .mem_target(mtgt),
        .imem_addr(a_addr[0]), .imem_rdata(a_rdata[0]), .pc_out(a_pc[0]),
        .id_pc(a_idpc[0]), .id_instr(a_idin[0]), .id_valid(a_idv[0]),
        .redirect(a_red[0]), .fetch_count(fc0));

    if_fetch_stage #(.RESET_PC(32'h8), .PC_STEP(32'd1), .SQUASH_CYCLES(3), .PERF_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .wb_BranchZ(bz), .wb_BranchN(bn), .wb_Jump(jmp), .wb_JumpMem(jmem),
        .wb_Z(fz), .wb_N(fn), .reg_target(rtgt), .mem_target(mtgt),
        .imem_addr(a_addr[1]), .imem_rdata(a_rdata[1]), .pc_out(a_pc[1]),
        .id_pc(a_idpc[1]), .id_instr(a_idin[1]), .id_valid(a_idv[1]),
        .redirect(a_red[1]), .fetch_count(fc1));

    assign a_fc[0] = fc0;
    assign a_fc[1] = {28'd0, fc1};

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // synchronous-read instruction memories
    always @(posedge clk) begin
        a_rdata[0] <= imem(a_addr[0]);
        a_rdata[1] <= imem(a_addr[1]);
    end

    function automatic int sq(input int k);
        return (k == 0) ? 1 : 3;
    endfunction
    function automatic logic [31:0] rstpc(input int k);
        return (k == 0) ? 32'h0 : 32'h8;
    endfunction
    function automatic logic [31:0] fcmax(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'd15;
    endfunction

    typedef struct {
        logic        red;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] idpc;
        logic [31:0] idin;
        logic        idv;
        logic [31:0] fc;
    } exp_t;

    exp_t q0[$], q1[$];

    // reference model: architectural view of the fetch stream
    logic [31:0] m_pc[2], m_idpc[2], m_idin[2], m_fc[2];
    bit          m_idv[2], m_boot[2];
    int          m_left[2];

    int total = 0;
    int bad = 0;

    function automatic void model_reset(input int k);
        m_pc[k] = rstpc(k); m_idpc[k] = '0; m_idin[k] = '0; m_fc[k] = '0;
        m_idv[k] = 0; m_boot[k] = 1; m_left[k] = 0;
    endfunction

    function automatic void model_step(input int k, input bit red, input logic [31:0] tgt, input bit st);
        if (red) begin
            m_pc[k] = tgt; m_idv[k] = 0; m_left[k] = sq(k) - 1; m_boot[k] = 0;
        end else if (m_boot[k]) begin
            m_boot[k] = 0;
        end else if (!st) begin
            m_idpc[k] = m_pc[k];
            m_idin[k] = imem(m_pc[k]);
            if (m_left[k] > 0) begin
                m_idv[k] = 0; m_left[k]--;
            end else begin
                m_idv[k] = 1;
                if (m_fc[k] != fcmax(k)) m_fc[k]++;
            end
            m_pc[k] = m_pc[k] + 32'd1;
        end
    endfunction

    task automatic cyc(input bit st, input bit ibz, input bit ibn, input bit ij, input bit ijm,
                       input bit iz, input bit in_, input logic [31:0] rt, input logic [31:0] mt,
                       input bit rst_assert);
        bit          red;
        logic [31:0] tgt;
        exp_t        e;
        @(posedge clk);
        #2;
        rst_n = !rst_assert;
        stall = st; bz = ibz; bn = ibn; jmp = ij; jmem = ijm; fz = iz; fn = in_;
        rtgt = rt; mtgt = mt;
        red = ij | ijm | (ibz & iz) | (ibn & in_);
        tgt = ijm ? mt : rt;
        for (int k = 0; k < 2; k++) begin
            if (rst_assert) model_reset(k);
            e.red  = red;
            e.addr = m_boot[k] ? rstpc(k) : red ? tgt : st ? m_pc[k] : m_pc[k] + 32'd1;
            e.pc   = m_pc[k];
            e.idpc = m_idpc[k];
            e.idin = m_idin[k];
            e.idv  = m_idv[k];
            e.fc   = m_fc[k];
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            if (!rst_assert) model_step(k, red, tgt, st);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, k, $time, act, req);
        end
    endtask

    task automatic check_one(input int k, input exp_t e);
        chk("redirect", k, {31'd0, a_red[k]}, {31'd0, e.red});
        chk("imem_addr", k, a_addr[k], e.addr);
        chk("pc_out", k, a_pc[k], e.pc);
        chk("id_valid", k, {31'd0, a_idv[k]}, {31'd0, e.idv});
        chk("fetch_count", k, a_fc[k], e.fc);
        if (e.idv || (e.idpc == 32'd0 && e.idin == 32'd0 && e.fc == 32'd0)) begin
            chk("id_pc", k, a_idpc[k], e.idpc);
            chk("id_instr", k, a_idin[k], e.idin);
        end
    endtask

    // monitor: drains whatever the stimulus has queued for this cycle
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_one(0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_one(1, e);
        end
    end

    initial begin
        model_reset(0);
        model_reset(1);
        cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        run(10);
        // stall hold
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        run(4);
        // BranchZ taken, then not taken, then BranchN taken
        cyc(0, 1, 0, 0, 0, 1, 0, 32'h40, 32'h0, 0);
        run(5);
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h60, 32'h0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, 32'h100, 32'h0, 0);
        run(5);
        // JumpMem and Jump together: mem target wins
        cyc(0, 0, 0, 1, 1, 0, 0, 32'h20, 32'h80, 0);
        run(6);
        // redirect beats stall
        cyc(1, 0, 0, 1, 0, 0, 0, 32'h200, 32'h0, 0);
        run(4);
        // PC wraparound
        cyc(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, 32'h0, 0);
        run(6);
        // redirect during flush, then stall freezing the squash window
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h300, 32'h0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h400, 32'h0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        run(6);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 12) == 0,
                ($urandom % 16) == 0, ($urandom % 16) == 0, $urandom % 2 == 1, $urandom % 2 == 1,
                $urandom, $urandom, 0);
        end
        run(4);
        // async reset in the middle of a squash window
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h500, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        run(6);
        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
